pipe_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage MIPS pipeline. It drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard classes with fixed priority: data-memory wait, taken branch and load-use. A wait-cycle counter bounds memory stalls and latches a sticky fault on timeout.

---
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory wait > taken branch > load-use.
// Optional perf counters (stall_cycles, flush_events) when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_dst,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mem_wb_flush,
  output logic       mem_fault
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] wait_cnt_inc;

  logic load_use;
  logic mem_wait;
  logic br_hit;
  logic lu_hit;

  assign load_use = ex_mem_read && (ex_dst != 5'd0) &&
                    ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
  assign mem_wait = mem_req && !dmem_ready;
  assign br_hit   = ex_branch_taken && !mem_wait;
  assign lu_hit   = load_use && !ex_branch_taken && !mem_wait;

  assign wait_cnt_inc = wait_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;

    if (state_q != FAULT) begin
      if (mem_wait) begin
        // Front end frozen; MEM_WB takes a bubble so the stalled access retires once.
        mem_wb_en    = 1'b1;
        mem_wb_flush = 1'b1;
        if (state_q == RUN) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (wait_cnt_inc == TIMEOUT_C) begin
          state_d    = FAULT;
          wait_cnt_d = TIMEOUT_C;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end else begin
        state_d    = RUN;
        wait_cnt_d = '0;
        pc_en      = 1'b1;
        if_id_en   = 1'b1;
        id_ex_en   = 1'b1;
        ex_mem_en  = 1'b1;
        mem_wb_en  = 1'b1;
        if (br_hit) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (lu_hit) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
    end

    // Hold the whole pipeline still while reset is asserted.
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
    end
  end

  assign mem_fault = (state_q == FAULT);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, flush_events_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else if (state_q != FAULT) begin
      if (mem_wait || lu_hit) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (br_hit)             flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule
